// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage: occupancy state encoding and count width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_CNT_W = 2;

    function automatic logic [PIPE_CNT_W-1:0] state_count(input pipe_state_e st);
        logic [PIPE_CNT_W-1:0] cnt;
        case (st)
            ST_MAIN: cnt = 2'd1;
            ST_FULL: cnt = 2'd2;
            default: cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload register for one stage entry: {ctrl, data} with load enable.
// Clearing only zeroes ctrl, so data keeps its last value across a flush.
module pipe_payload_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_clear_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_data <= '0;
            o_ctrl <= '0;
        end else if (i_clear_ctrl) begin
            o_ctrl <= '0;
        end else if (i_load) begin
            o_data <= i_data;
            o_ctrl <= i_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid and flush.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held, o_valid=0
//   ST_MAIN  | one entry in main, presented downstream
//   ST_FULL  | main presented, skid holds the next entry, o_ready=0
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_W-1:0]     i_data,
    input  logic [CTRL_W-1:0]     i_ctrl,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_W-1:0]     o_data,
    output logic [CTRL_W-1:0]     o_ctrl,
    output logic [PIPE_CNT_W-1:0] o_count
);

    logic              xfer_in;
    logic              xfer_out;
    logic              stage_ready;
    logic              stage_valid;
    logic [PIPE_CNT_W-1:0] stage_count;
    logic              main_load;
    logic [DATA_W-1:0] main_din_data;
    logic [CTRL_W-1:0] main_din_ctrl;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;

    assign xfer_in  = i_valid & stage_ready;
    assign xfer_out = stage_valid & i_ready;

    pipe_payload_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (main_load),
        .i_clear_ctrl (i_flush),
        .i_data       (main_din_data),
        .i_ctrl       (main_din_ctrl),
        .o_data       (main_data_q),
        .o_ctrl       (main_ctrl_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_e       state_q;
            pipe_state_e       state_d;
            logic              ready_q;
            logic              skid_load;
            logic              main_from_skid;
            logic [DATA_W-1:0] skid_data_q;
            logic [CTRL_W-1:0] skid_ctrl_q;

            always_ff @(posedge i_clk) begin
                if (!i_reset) begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != ST_FULL);
                end
            end

            // Flush overrides every handshake; an accepted input that cycle is dropped.
            always_comb begin
                state_d = state_q;
                if (i_flush) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: if (xfer_in) state_d = ST_MAIN;
                        ST_MAIN: begin
                            if (xfer_in && !xfer_out)      state_d = ST_FULL;
                            else if (!xfer_in && xfer_out) state_d = ST_EMPTY;
                        end
                        ST_FULL:  if (xfer_out) state_d = ST_MAIN;
                        default:  state_d = ST_EMPTY;
                    endcase
                end
            end

            always_comb begin
                main_load      = 1'b0;
                skid_load      = 1'b0;
                main_from_skid = 1'b0;
                if (!i_flush) begin
                    case (state_q)
                        ST_EMPTY: main_load = xfer_in;
                        ST_MAIN: begin
                            main_load = xfer_in & xfer_out;
                            skid_load = xfer_in & ~xfer_out;
                        end
                        ST_FULL: begin
                            main_load      = xfer_out;
                            main_from_skid = 1'b1;
                        end
                        default: main_load = 1'b0;
                    endcase
                end
            end

            pipe_payload_reg #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .i_clk        (i_clk),
                .i_reset      (i_reset),
                .i_load       (skid_load),
                .i_clear_ctrl (i_flush),
                .i_data       (i_data),
                .i_ctrl       (i_ctrl),
                .o_data       (skid_data_q),
                .o_ctrl       (skid_ctrl_q)
            );

            assign main_din_data = main_from_skid ? skid_data_q : i_data;
            assign main_din_ctrl = main_from_skid ? skid_ctrl_q : i_ctrl;
            assign stage_ready   = ready_q;
            assign stage_valid   = (state_q != ST_EMPTY);
            assign stage_count   = state_count(state_q);
        end else begin : g_single
            logic valid_q;

            always_ff @(posedge i_clk) begin
                if (!i_reset)     valid_q <= 1'b0;
                else if (i_flush) valid_q <= 1'b0;
                else if (xfer_in) valid_q <= 1'b1;
                else if (xfer_out) valid_q <= 1'b0;
            end

            // Combinational ready: a draining entry frees the slot in the same cycle.
            assign stage_ready   = ~valid_q | i_ready;
            assign main_load     = xfer_in & ~i_flush;
            assign main_din_data = i_data;
            assign main_din_ctrl = i_ctrl;
            assign stage_valid   = valid_q;
            assign stage_count   = {1'b0, valid_q};
        end
    endgenerate

    assign o_ready = stage_ready;
    assign o_valid = stage_valid;
    assign o_data  = main_data_q;
    assign o_ctrl  = stage_valid ? main_ctrl_q : '0;
    assign o_count = stage_count;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks of pipe_stage_skid with SKID=1 (a_*) and SKID=0 (b_*).
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst_n;
    logic        a_flush, a_valid, a_ready, a_o_ready, a_o_valid;
    logic [31:0] a_data, a_o_data;
    logic [7:0]  a_ctrl, a_o_ctrl;
    logic [1:0]  a_o_count;
    logic        b_flush, b_valid, b_ready, b_o_ready, b_o_valid;
    logic [31:0] b_data, b_o_data;
    logic [7:0]  b_ctrl, b_o_ctrl;
    logic [1:0]  b_o_count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [39:0] q0[$];
    logic [39:0] q1[$];
    logic        prev_stall [2];
    logic [31:0] prev_data  [2];

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_skid (
        .i_clk(clk), .i_reset(rst_n), .i_flush(a_flush), .i_valid(a_valid),
        .o_ready(a_o_ready), .i_data(a_data), .i_ctrl(a_ctrl), .o_valid(a_o_valid),
        .i_ready(a_ready), .o_data(a_o_data), .o_ctrl(a_o_ctrl), .o_count(a_o_count)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_single (
        .i_clk(clk), .i_reset(rst_n), .i_flush(b_flush), .i_valid(b_valid),
        .o_ready(b_o_ready), .i_data(b_data), .i_ctrl(b_ctrl), .o_valid(b_o_valid),
        .i_ready(b_ready), .o_data(b_o_data), .o_ctrl(b_o_ctrl), .o_count(b_o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard step for one DUT, called with inputs driven and outputs settled.
    task automatic sb_step(input int w, input logic vld, input logic rdy, input logic fl,
                           input logic [31:0] din, input logic [7:0] cin,
                           input logic ovld, input logic ordy, input logic [31:0] odat,
                           input logic [7:0] octl, input logic [1:0] ocnt);
        logic [39:0] e;
        int          sz;
        sz = (w == 0) ? q0.size() : q1.size();
        chk("rnd_count", {30'd0, ocnt}, sz);
        chk("rnd_valid", {31'd0, ovld}, {31'd0, sz != 0});
        if (!ovld) chk("rnd_ctrl_bubble", {24'd0, octl}, 32'd0);
        if (prev_stall[w]) chk("rnd_stable_data", odat, prev_data[w]);
        if (ovld && rdy && sz != 0) begin
            if (w == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("rnd_order_data", odat, e[31:0]);
            chk("rnd_order_ctrl", {24'd0, octl}, {24'd0, e[39:32]});
        end
        if (fl) begin
            if (w == 0) q0.delete();
            else        q1.delete();
        end else if (vld && ordy) begin
            if (w == 0) q0.push_back({cin, din});
            else        q1.push_back({cin, din});
        end
        prev_stall[w] = ovld & ~rdy & ~fl;
        prev_data[w]  = odat;
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_valid = 1; a_ready = 1; a_data = 32'h99; a_ctrl = 8'h77;
        b_flush = 0; b_valid = 0; b_ready = 0; b_data = 32'h0;  b_ctrl = 8'h0;
        prev_stall[0] = 0; prev_stall[1] = 0; prev_data[0] = 0; prev_data[1] = 0;

        // reset held with valid input
        repeat (3) begin
            tick();
            chk("rst_valid", {31'd0, a_o_valid}, 32'd0);
            chk("rst_ctrl",  {24'd0, a_o_ctrl}, 32'd0);
            chk("rst_count", {30'd0, a_o_count}, 32'd0);
        end
        rst_n = 1'b1; a_valid = 0;
        tick();
        chk("rel_ready", {31'd0, a_o_ready}, 32'd1);
        chk("rel_valid", {31'd0, a_o_valid}, 32'd0);

        // streaming
        a_ready = 1;
        for (int k = 0; k < 16; k++) begin
            a_valid = 1; a_data = 32'h10 + k; a_ctrl = 8'(k + 1);
            tick();
            chk("stream_data",  a_o_data, 32'h10 + k);
            chk("stream_ctrl",  {24'd0, a_o_ctrl}, k + 1);
            chk("stream_count", {30'd0, a_o_count}, 32'd1);
        end
        a_valid = 0;
        tick();
        chk("stream_drain_valid", {31'd0, a_o_valid}, 32'd0);
        chk("stream_drain_count", {30'd0, a_o_count}, 32'd0);

        // stall into skid
        a_ready = 0; a_valid = 1; a_data = 32'hA; a_ctrl = 8'h5A;
        tick();
        chk("stall_a_count", {30'd0, a_o_count}, 32'd1);
        chk("stall_a_data",  a_o_data, 32'hA);
        chk("stall_a_ready", {31'd0, a_o_ready}, 32'd1);
        a_data = 32'hB; a_ctrl = 8'h5B;
        tick();
        chk("stall_full_count", {30'd0, a_o_count}, 32'd2);
        chk("stall_full_ready", {31'd0, a_o_ready}, 32'd0);
        chk("stall_full_data",  a_o_data, 32'hA);
        a_data = 32'hEE; a_ctrl = 8'hEE;
        tick();
        chk("stall_hold_count", {30'd0, a_o_count}, 32'd2);
        chk("stall_hold_data",  a_o_data, 32'hA);
        chk("stall_hold_ctrl",  {24'd0, a_o_ctrl}, 32'h5A);
        a_valid = 0; a_ready = 1;
        tick();
        chk("drain_b_data",  a_o_data, 32'hB);
        chk("drain_b_ctrl",  {24'd0, a_o_ctrl}, 32'h5B);
        chk("drain_b_count", {30'd0, a_o_count}, 32'd1);
        tick();
        chk("drain_end_valid", {31'd0, a_o_valid}, 32'd0);
        chk("drain_end_ready", {31'd0, a_o_ready}, 32'd1);

        // flush while full, with C offered
        a_ready = 0; a_valid = 1; a_data = 32'hA; a_ctrl = 8'h5A;
        tick();
        a_data = 32'hB; a_ctrl = 8'h5B;
        tick();
        a_flush = 1; a_data = 32'hC; a_ctrl = 8'h5C;
        tick();
        chk("flush_valid", {31'd0, a_o_valid}, 32'd0);
        chk("flush_ctrl",  {24'd0, a_o_ctrl}, 32'd0);
        chk("flush_count", {30'd0, a_o_count}, 32'd0);
        chk("flush_data_held", a_o_data, 32'hA);
        chk("flush_ready", {31'd0, a_o_ready}, 32'd1);
        a_flush = 0; a_valid = 0; a_ready = 1;
        repeat (2) begin
            tick();
            chk("flush_no_c", {31'd0, a_o_valid}, 32'd0);
        end

        // flush beats a same-cycle accept in MAIN
        a_valid = 1; a_data = 32'hD; a_ctrl = 8'h5D;
        tick();
        chk("main_d_data", a_o_data, 32'hD);
        a_flush = 1; a_ready = 0; a_data = 32'hE; a_ctrl = 8'h5E;
        tick();
        chk("flush_acc_valid", {31'd0, a_o_valid}, 32'd0);
        chk("flush_acc_data",  a_o_data, 32'hD);
        a_flush = 0; a_valid = 0;
        tick();
        chk("flush_acc_no_e", {31'd0, a_o_valid}, 32'd0);

        // SKID=0 combinational ready
        b_valid = 1; b_data = 32'h21; b_ctrl = 8'h61; b_ready = 0;
        #1;
        chk("s0_empty_ready", {31'd0, b_o_ready}, 32'd1);
        tick();
        chk("s0_valid", {31'd0, b_o_valid}, 32'd1);
        chk("s0_data",  b_o_data, 32'h21);
        chk("s0_count", {30'd0, b_o_count}, 32'd1);
        chk("s0_stall_ready", {31'd0, b_o_ready}, 32'd0);
        b_data = 32'h22; b_ctrl = 8'h62;
        tick();
        chk("s0_hold_data", b_o_data, 32'h21);
        b_ready = 1;
        #1;
        chk("s0_comb_ready", {31'd0, b_o_ready}, 32'd1);
        tick();
        chk("s0_new_data", b_o_data, 32'h22);
        chk("s0_new_ctrl", {24'd0, b_o_ctrl}, 32'h62);
        b_valid = 0;
        tick();
        chk("s0_drain_valid", {31'd0, b_o_valid}, 32'd0);
        chk("s0_drain_count", {30'd0, b_o_count}, 32'd0);

        // mid-transfer reset drops entries
        a_valid = 1; a_ready = 0; a_data = 32'h55; b_valid = 1; b_ready = 0; b_data = 32'h55;
        tick();
        chk("mid_pre_count", {30'd0, a_o_count}, 32'd1);
        rst_n = 0;
        tick();
        chk("mid_rst_count_a", {30'd0, a_o_count}, 32'd0);
        chk("mid_rst_count_b", {30'd0, b_o_count}, 32'd0);
        rst_n = 1; a_valid = 0; b_valid = 0;
        tick();

        // randomised traffic with scoreboards on both variants
        for (int i = 0; i < 10000; i++) begin
            a_valid = 1'($urandom);
            a_ready = 1'($urandom);
            a_flush = ($urandom_range(0, 15) == 0);
            a_data  = 32'h1000 + i;
            a_ctrl  = {1'b1, 7'(i)};
            b_valid = a_valid; b_ready = a_ready; b_flush = a_flush;
            b_data  = a_data;  b_ctrl  = a_ctrl;
            #1;
            sb_step(0, a_valid, a_ready, a_flush, a_data, a_ctrl,
                    a_o_valid, a_o_ready, a_o_data, a_o_ctrl, a_o_count);
            sb_step(1, b_valid, b_ready, b_flush, b_data, b_ctrl,
                    b_o_valid, b_o_ready, b_o_data, b_o_ctrl, b_o_count);
            if (b_o_count > 2'd1) chk("s0_count_max", {30'd0, b_o_count}, 32'd1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
